// File: rtl/rr_arbiter_enc_4x2.sv
// Four-requester round-robin arbiter with registered one-hot and encoded grant.
// A grant is held until done, request drop or hold timeout, followed by one dead cycle.
module rr_arbiter_enc_4x2 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam bit             HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [1:0]       r_state;
   logic [1:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_grant;
   logic [1:0]       r_idx;
   logic             r_valid;

   logic [1:0]       w_state_nxt;
   logic [1:0]       w_ptr_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [3:0]       w_grant_nxt;
   logic [1:0]       w_idx_nxt;
   logic             w_valid_nxt;

   logic             w_arb_found;
   logic [1:0]       w_arb_idx;
   logic             w_release;

   // First active request scanning from the priority pointer, wrapping mod 4
   always_comb begin
      logic [1:0] w_scan;
      w_arb_found = 1'b0;
      w_arb_idx   = r_ptr;
      w_scan      = r_ptr;
      for (int k = 0; k < 4; k++) begin
         w_scan = r_ptr + 2'(k);
         if (!w_arb_found && req[w_scan]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_scan;
         end
      end
   end

   // Only the owner's done/req are looked at; timeout and done collapse into one release
   assign w_release = done[r_idx] | ~req[r_idx] | (HOLD_EN && (r_cnt == HOLD_LAST));

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_grant_nxt = r_grant;
      w_idx_nxt   = r_idx;
      w_valid_nxt = r_valid;
      case (r_state)
         S_IDLE, S_GAP: begin
            if (w_arb_found) begin
               w_state_nxt = S_GRANT;
               w_grant_nxt = 4'b0001 << w_arb_idx;
               w_idx_nxt   = w_arb_idx;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = '0;
            end else begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = 4'b0000;
               w_idx_nxt   = 2'd0;
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = '0;
            end
         end
         S_GRANT: begin
            if (w_release) begin
               w_state_nxt = S_GAP;
               w_grant_nxt = 4'b0000;
               w_idx_nxt   = 2'd0;
               w_valid_nxt = 1'b0;
               w_ptr_nxt   = r_idx + 2'd1;
               w_cnt_nxt   = '0;
            end else if (r_cnt != CNT_MAX) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
            w_idx_nxt   = 2'd0;
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= 2'd0;
         r_cnt   <= '0;
         r_grant <= 4'b0000;
         r_idx   <= 2'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_grant <= w_grant_nxt;
         r_idx   <= w_idx_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;

endmodule

// File: tb/tb_rr_arbiter_enc_4x2.sv
// Directed bench for rr_arbiter_enc_4x2: per-cycle vector table plus
// hand-written timeout and asynchronous-reset sequences.
module tb_rr_arbiter_enc_4x2;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] done;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;

   int n_checks;
   int n_errors;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [1:0] idx;
      logic       valid;
   } vec_t;

   localparam int NVEC = 32;
   vec_t vecs [NVEC];

   rr_arbiter_enc_4x2 #(.MAX_HOLD(8), .CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .done       (done),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .grant_valid(grant_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] eg, input logic [1:0] ei, input logic ev);
      n_checks++;
      if (grant !== eg || grant_idx !== ei || grant_valid !== ev) begin
         n_errors++;
         $display("FAIL %s: got grant=%b idx=%b valid=%b, expected grant=%b idx=%b valid=%b",
                  name, grant, grant_idx, grant_valid, eg, ei, ev);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // Owner 2 granted, done[2] releases, ptr=3 then wins 1111
      vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
      vecs[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
      vecs[2]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
      vecs[3]  = '{4'b0100, 4'b0100, 4'b0000, 2'd0, 1'b0};
      vecs[4]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
      // Full rotation with one dead cycle between grants
      vecs[5]  = '{4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0};
      vecs[6]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[7]  = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
      vecs[8]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
      vecs[9]  = '{4'b1111, 4'b0010, 4'b0000, 2'd0, 1'b0};
      vecs[10] = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
      vecs[11] = '{4'b1111, 4'b0100, 4'b0000, 2'd0, 1'b0};
      vecs[12] = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
      vecs[13] = '{4'b1111, 4'b1000, 4'b0000, 2'd0, 1'b0};
      vecs[14] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[15] = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0};
      // Owner 1 drops its request; ptr=2 wraps to requester 0
      vecs[16] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1};
      vecs[17] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1};
      vecs[18] = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[19] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      // Foreign done and foreign req ignored; done[0] coincides with timeout
      vecs[20] = '{4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1};
      vecs[21] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[22] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[23] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[24] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[25] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[26] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1};
      vecs[27] = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0};
      vecs[28] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1};
      vecs[29] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[30] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
      vecs[31] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

      // Reset held with all requests active
      rst  = 1'b1;
      req  = 4'b1111;
      done = 4'b0000;
      #1;
      check("reset_initial", 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 4'b0000);
         check($sformatf("reset_hold_%0d", i), 4'b0000, 2'd0, 1'b0);
      end
      req = 4'b0000;
      rst = 1'b0;
      step(4'b0000, 4'b0000);
      check("idle_after_reset", 4'b0000, 2'd0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         step(vecs[i].req, vecs[i].done);
         check($sformatf("vec_%0d", i), vecs[i].grant, vecs[i].idx, vecs[i].valid);
      end

      // Lone requester: 8 grant cycles, one gap, repeating (ptr=2 here)
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 0; k < 8; k++) begin
            step(4'b0001, 4'b0000);
            check($sformatf("timeout_r%0d_hold_%0d", rep, k), 4'b0001, 2'd0, 1'b1);
         end
         step(4'b0001, 4'b0000);
         check($sformatf("timeout_r%0d_gap", rep), 4'b0000, 2'd0, 1'b0);
      end
      step(4'b0001, 4'b0000);
      check("timeout_regrant", 4'b0001, 2'd0, 1'b1);

      // Grant 1000 then assert reset mid-cycle
      step(4'b1000, 4'b0000);
      check("drop_before_reset", 4'b0000, 2'd0, 1'b0);
      step(4'b1000, 4'b0000);
      check("grant_before_reset", 4'b1000, 2'd3, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_midcycle", 4'b0000, 2'd0, 1'b0);
      step(4'b1000, 4'b0000);
      check("async_reset_held", 4'b0000, 2'd0, 1'b0);
      rst = 1'b0;
      // ptr back at 0: requester 0 beats requester 3
      step(4'b1001, 4'b0000);
      check("ptr_after_reset", 4'b0001, 2'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
